mem_access_ctrl: RTL and testbench

//  Sequences load/store operations leaving the execute stage (op_type=1) onto a single-master
//  req/ack data bus. Holds the pipeline via o_stall until the bus access completes.

---
 rtl/mem_access_ctrl_pkg.sv | 59 +++++
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_load_align.sv | 29 ++
 rtl/mem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants, request bundle and lane helpers
// for the load/store bus sequencer.
package mem_access_ctrl_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [4:0]  rd;
   } req_t;

   function automatic logic f3_legal(logic st, logic [2:0] f3);
      if (st)
         return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   function automatic logic misaligned(logic [2:0] f3, logic [1:0] a);
      return ((f3[1:0] == 2'b01) && a[0]) ||
             ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

   function automatic logic [3:0] lane_be(logic [2:0] f3, logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(logic [2:0] f3, logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Single-master req/ack data bus.
// master = sequencer, slave = memory side.
interface mem_access_ctrl_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata, bus_err
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata, bus_err
   );

endinterface

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension
// from the raw bus word.
module mem_load_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_func_3,
   output logic [31:0] o_data
);

   logic [7:0]  b;
   logic [15:0] h;

   // pick the addressed lane, then extend by width/sign
   always_comb begin
      b      = i_rdata[{i_addr, 3'b000} +: 8];
      h      = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_data = i_rdata;
      case (i_func_3)
         F3_LB:   o_data = {{24{b[7]}}, b};
         F3_LBU:  o_data = {24'd0, b};
         F3_LH:   o_data = {{16{h[15]}}, h};
         F3_LHU:  o_data = {16'd0, h};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute and write-back.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic              i_op_type,
   input  logic [6:0]        i_opcode,
   input  logic [2:0]        i_func_3,
   input  logic [31:0]       i_alu_out,
   input  logic [31:0]       i_rs_2,
   input  logic [4:0]        i_rd_num,
   output logic              o_stall,
   mem_access_ctrl_if.master bus,
   output logic              o_wb_valid,
   output logic [4:0]        o_wb_rd,
   output logic [31:0]       o_wb_data,
   output logic              o_fault
);

   state_e            state_q, state_d;
   req_t              req_q, req_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              fault_q, fault_d;

   logic              is_ld, is_st;
   logic              accept, bad, issue;
   logic              busy, timeout, ack;
   logic [31:0]       ld_data;

   assign is_ld  = i_opcode == OP_LOAD;
   assign is_st  = i_opcode == OP_STORE;
   assign accept = (state_q == S_IDLE) & i_valid & i_op_type &
                   (is_ld | is_st);

`ifdef MISALIGN_TRAP_EN
   assign bad = ~f3_legal(is_st, i_func_3) |
                misaligned(i_func_3, i_alu_out[1:0]);
`else
   assign bad = ~f3_legal(is_st, i_func_3);
`endif

   assign issue   = accept & ~bad;
   assign busy    = state_q == S_BUSY;
   assign timeout = busy & (cnt_q == TO_W'(TIMEOUT_CYCLES));
   assign ack     = busy & ~timeout & bus.bus_ack;

   mem_load_align u_align (
      .i_rdata  (bus.bus_rdata),
      .i_addr   (req_q.addr[1:0]),
      .i_func_3 (req_q.f3),
      .o_data   (ld_data)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next state: issue opens BUSY, ack or timeout closes it
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (issue) state_d = S_BUSY;
         S_BUSY:  if (timeout | ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: stall in accept cycle and until ack
   always_comb begin
      o_stall     = accept | (busy & ~timeout & ~bus.bus_ack);
      bus.bus_req = busy & ~timeout;
   end

   // request capture, timeout count, write-back and fault next values
   always_comb begin
      req_d      = req_q;
      cnt_d      = cnt_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      if (issue) begin
         req_d.we    = is_st;
         req_d.addr  = i_alu_out;
         req_d.be    = lane_be(i_func_3, i_alu_out[1:0]);
         req_d.wdata = lane_wdata(i_func_3, i_rs_2);
         req_d.f3    = i_func_3;
         req_d.rd    = i_rd_num;
         cnt_d       = '0;
      end else if (busy & ~ack & ~timeout) begin
         cnt_d = cnt_q + TO_W'(1);
      end
      wb_valid_d = ack & ~bus.bus_err & ~req_q.we;
      if (wb_valid_d) begin
         wb_rd_d   = req_q.rd;
         wb_data_d = ld_data;
      end
      fault_d = (accept & bad) | timeout | (ack & bus.bus_err);
   end

   // datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q      <= '0;
         cnt_q      <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         fault_q    <= 1'b0;
      end else begin
         req_q      <= req_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         fault_q    <= fault_d;
      end
   end

   assign bus.bus_we    = req_q.we;
   assign bus.bus_addr  = {req_q.addr[31:2], 2'b00};
   assign bus.bus_be    = req_q.be;
   assign bus.bus_wdata = req_q.wdata;

   assign o_wb_valid = wb_valid_q;
   assign o_wb_rd    = wb_rd_q;
   assign o_wb_data  = wb_data_q;
   assign o_fault    = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed loads/stores,
// faults, timeout, reset while busy, optional misalign trap.
module tb_mem_access_ctrl;

   localparam int TO = 5;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] ALU = 7'b0110011;

   typedef struct {
      bit          fault;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          chk_be;
      bit          chk_wd;
   } bus_exp_t;

   logic        clk, rst_n;
   logic        i_valid, i_op_type;
   logic [6:0]  i_opcode;
   logic [2:0]  i_func_3;
   logic [31:0] i_alu_out, i_rs_2;
   logic [4:0]  i_rd_num;
   logic        o_stall, o_wb_valid, o_fault;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;

   mem_access_ctrl_if bus_if ();

   mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_op_type  (i_op_type),
      .i_opcode   (i_opcode),
      .i_func_3   (i_func_3),
      .i_alu_out  (i_alu_out),
      .i_rs_2     (i_rs_2),
      .i_rd_num   (i_rd_num),
      .o_stall    (o_stall),
      .bus        (bus_if),
      .o_wb_valid (o_wb_valid),
      .o_wb_rd    (o_wb_rd),
      .o_wb_data  (o_wb_data),
      .o_fault    (o_fault)
   );

   int nvec = 0;
   int nmis = 0;
   wb_exp_t  wq[$];
   bus_exp_t bq[$];

   int          ack_dly = 0;
   bit          no_ack = 0;
   logic [31:0] s_rdata = '0;
   bit          s_err = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_bus(input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          input bit cbe, input bit cwd);
      bus_exp_t e;
      e.we = we; e.addr = a; e.be = be; e.wdata = wd;
      e.chk_be = cbe; e.chk_wd = cwd;
      bq.push_back(e);
   endtask

   task automatic exp_wb(input bit f, input logic [4:0] rd,
                         input logic [31:0] d);
      wb_exp_t e;
      e.fault = f; e.rd = rd; e.data = d;
      wq.push_back(e);
   endtask

   // memory model: checks request fields, holds them, acks after ack_dly
   initial begin : slave
      int scnt;
      bus_exp_t cap;
      bus_exp_t e;
      scnt = 0;
      bus_if.bus_ack   = 0;
      bus_if.bus_rdata = '0;
      bus_if.bus_err   = 0;
      forever begin
         @(posedge clk);
         #1;
         bus_if.bus_ack = 0;
         bus_if.bus_err = 0;
         if (bus_if.bus_req) begin
            if (scnt == 0) begin
               cap.we = bus_if.bus_we; cap.addr = bus_if.bus_addr;
               cap.be = bus_if.bus_be; cap.wdata = bus_if.bus_wdata;
               if (bq.size() == 0) begin
                  chk("bus_unexpected_req", 64'(bus_if.bus_req), 64'(0));
               end else begin
                  e = bq.pop_front();
                  chk("bus_we", 64'(bus_if.bus_we), 64'(e.we));
                  chk("bus_addr", 64'(bus_if.bus_addr), 64'(e.addr));
                  if (e.chk_be)
                     chk("bus_be", 64'(bus_if.bus_be), 64'(e.be));
                  if (e.chk_wd)
                     chk("bus_wdata", 64'(bus_if.bus_wdata), 64'(e.wdata));
               end
            end else begin
               chk("bus_hold",
                   {27'd0, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr},
                   {27'd0, cap.we, cap.be, cap.addr});
               chk("bus_hold_wd", 64'(bus_if.bus_wdata), 64'(cap.wdata));
            end
            if (!no_ack && scnt == ack_dly) begin
               bus_if.bus_ack   = 1;
               bus_if.bus_rdata = s_rdata;
               bus_if.bus_err   = s_err;
            end
            scnt++;
         end else begin
            scnt = 0;
         end
      end
   end

   // write-back / fault monitor pops the scoreboard on every pulse
   always @(negedge clk) begin
      wb_exp_t e;
      if (rst_n && (o_wb_valid || o_fault)) begin
         if (wq.size() == 0) begin
            chk("wb_unexpected", 64'({o_wb_valid, o_fault}), 64'(0));
         end else begin
            e = wq.pop_front();
            chk("wb_kind", 64'({o_wb_valid, o_fault}),
                e.fault ? 64'(2'b01) : 64'(2'b10));
            if (!e.fault)
               chk("wb_data", 64'({o_wb_rd, o_wb_data}),
                   64'({e.rd, e.data}));
         end
      end
   end

   task automatic op(input string nm, input bit opt, input logic [6:0] opc,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] rs2, input logic [4:0] rd,
                     input int dly, input logic [31:0] rdat, input bit err,
                     input bit noack, input int exp_stall, input bit settle);
      int n;
      ack_dly = dly; s_rdata = rdat; s_err = err; no_ack = noack;
      @(posedge clk);
      #1;
      i_valid = 1; i_op_type = opt; i_opcode = opc; i_func_3 = f3;
      i_alu_out = a; i_rs_2 = rs2; i_rd_num = rd;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!o_stall) break;
         n++;
         @(posedge clk);
         #1;
         i_valid = 0;
      end
      i_valid = 0;
      chk({nm, "_stall"}, 64'(n), 64'(exp_stall));
      if (settle) begin
         repeat (2) @(negedge clk);
         chk({nm, "_drain"}, 64'(wq.size() + bq.size()), 64'(0));
      end
   endtask

   initial begin
      rst_n = 0; i_valid = 0; i_op_type = 0; i_opcode = '0;
      i_func_3 = '0; i_alu_out = '0; i_rs_2 = '0; i_rd_num = '0;
      #12;
      chk("rst_ctl", 64'({o_stall, bus_if.bus_req, bus_if.bus_we,
                          bus_if.bus_be, o_wb_valid, o_fault, o_wb_rd}), 64'(0));
      chk("rst_addr", 64'(bus_if.bus_addr), 64'(0));
      chk("rst_data", {bus_if.bus_wdata, o_wb_data}, 64'(0));
      @(negedge clk);
      rst_n = 1;

      exp_bus(0, 32'h100, 4'hF, 0, 1, 0);
      exp_wb(0, 5'd5, 32'hDEADBEEF);
      op("lw", 1, LD, 3'b010, 32'h100, 0, 5'd5, 0, 32'hDEADBEEF, 0, 0, 1, 1);

      exp_bus(0, 32'h100, 0, 0, 0, 0);
      exp_wb(0, 5'd6, 32'hFFFFFF80);
      op("lb", 1, LD, 3'b000, 32'h103, 0, 5'd6, 0, 32'h80123456, 0, 0, 1, 1);

      exp_bus(0, 32'h100, 0, 0, 0, 0);
      exp_wb(0, 5'd7, 32'h00000080);
      op("lbu", 1, LD, 3'b100, 32'h103, 0, 5'd7, 0, 32'h80123456, 0, 0, 1, 1);

      exp_bus(0, 32'h100, 0, 0, 0, 0);
      exp_wb(0, 5'd11, 32'hFFFFFFF1);
      op("lb1", 1, LD, 3'b000, 32'h101, 0, 5'd11, 0, 32'h0000F100, 0, 0, 1, 1);

      exp_bus(0, 32'h100, 0, 0, 0, 0);
      exp_wb(0, 5'd8, 32'hFFFF8001);
      op("lh", 1, LD, 3'b001, 32'h102, 0, 5'd8, 0, 32'h80011234, 0, 0, 1, 1);

      exp_bus(0, 32'h100, 0, 0, 0, 0);
      exp_wb(0, 5'd9, 32'h0000F234);
      op("lhu", 1, LD, 3'b101, 32'h100, 0, 5'd9, 0, 32'h8001F234, 0, 0, 1, 1);

      exp_bus(0, 32'h100, 0, 0, 0, 0);
      exp_wb(0, 5'd10, 32'h00007FFF);
      op("lh_pos", 1, LD, 3'b001, 32'h100, 0, 5'd10, 0, 32'h00007FFF, 0, 0, 1, 1);

      exp_bus(1, 32'h100, 4'b1100, 32'hABCDABCD, 1, 1);
      op("sh", 1, ST, 3'b001, 32'h102, 32'h1234ABCD, 0, TO - 1, 0, 0, 0, TO, 1);

      exp_bus(1, 32'h100, 4'b0010, 32'hA5A5A5A5, 1, 1);
      op("sb", 1, ST, 3'b000, 32'h101, 32'h000000A5, 0, 1, 0, 0, 0, 2, 1);

      exp_bus(1, 32'h204, 4'b1111, 32'hCAFEF00D, 1, 1);
      op("sw", 1, ST, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1, 1);

      exp_bus(0, 32'h300, 4'hF, 0, 1, 0);
      exp_wb(1, 0, 0);
      op("lw_err", 1, LD, 3'b010, 32'h300, 0, 5'd3, 2, 32'h12345678, 1, 0, 3, 1);

      exp_wb(1, 0, 0);
      op("ld_f3", 1, LD, 3'b011, 32'h100, 0, 5'd4, 0, 0, 0, 0, 1, 1);

      exp_wb(1, 0, 0);
      op("st_f3", 1, ST, 3'b100, 32'h100, 32'h1, 0, 0, 0, 0, 0, 1, 1);

      exp_bus(0, 32'h400, 4'hF, 0, 1, 0);
      exp_wb(1, 0, 0);
      op("tmo", 1, LD, 3'b010, 32'h400, 0, 5'd2, 0, 0, 0, 1, TO + 1, 1);

      exp_bus(0, 32'h404, 4'hF, 0, 1, 0);
      exp_wb(0, 5'd12, 32'h11223344);
      op("after_tmo", 1, LD, 3'b010, 32'h404, 0, 5'd12, 0, 32'h11223344, 0, 0, 1, 1);

      op("alu_op", 1, ALU, 3'b010, 32'h100, 0, 5'd1, 0, 0, 0, 0, 0, 1);
      op("no_optype", 0, LD, 3'b010, 32'h100, 0, 5'd1, 0, 0, 0, 0, 0, 1);

      exp_bus(0, 32'h600, 4'hF, 0, 1, 0);
      exp_wb(0, 5'd14, 32'hA5A50001);
      op("b2b_lw", 1, LD, 3'b010, 32'h600, 0, 5'd14, 0, 32'hA5A50001, 0, 0, 1, 0);
      exp_bus(1, 32'h604, 4'hF, 32'h55AA55AA, 1, 1);
      op("b2b_sw", 1, ST, 3'b010, 32'h604, 32'h55AA55AA, 0, 0, 0, 0, 0, 1, 1);

`ifdef MISALIGN_TRAP_EN
      exp_wb(1, 0, 0);
      op("lw_mis", 1, LD, 3'b010, 32'h102, 0, 5'd13, 0, 32'h01020304, 0, 0, 1, 1);
`else
      exp_bus(0, 32'h100, 4'hF, 0, 1, 0);
      exp_wb(0, 5'd13, 32'h01020304);
      op("lw_mis", 1, LD, 3'b010, 32'h102, 0, 5'd13, 0, 32'h01020304, 0, 0, 1, 1);
`endif

      exp_bus(0, 32'h500, 4'hF, 0, 1, 0);
      no_ack = 1;
      @(posedge clk);
      #1;
      i_valid = 1; i_op_type = 1; i_opcode = LD; i_func_3 = 3'b010;
      i_alu_out = 32'h500; i_rd_num = 5'd15;
      @(negedge clk);
      chk("rstb_stall", 64'(o_stall), 64'(1));
      @(posedge clk);
      #1;
      i_valid = 0;
      @(negedge clk);
      chk("rstb_req", 64'(bus_if.bus_req), 64'(1));
      rst_n = 0;
      #1;
      chk("rstb_drop", 64'({bus_if.bus_req, o_stall}), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1;
      no_ack = 0;
      repeat (3) @(negedge clk);
      chk("rstb_quiet", 64'(wq.size() + bq.size()), 64'(0));

      exp_bus(0, 32'h700, 4'hF, 0, 1, 0);
      exp_wb(0, 5'd16, 32'h0BADF00D);
      op("after_rst", 1, LD, 3'b010, 32'h700, 0, 5'd16, 0, 32'h0BADF00D, 0, 0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
